// File: rtl/dlock_pkg.sv
// dlock_pkg: shared state encoding, width helper and default code for the serial code lock
//   ST_LOCKED/ST_CHECK/ST_OPEN/ST_LOCKOUT : 2-bit FSM states
//   clog2()                               : ceil(log2(v)), usable in constant expressions
//   DEFAULT_CODE                          : factory code 6'b110100
package dlock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [5:0] DEFAULT_CODE = 6'b110100;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dlock_timer.sv
// dlock_timer: loadable down-counter that parks at zero and flags it
//   i_clk      : clock, rising edge
//   i_clear    : synchronous active-high reset (count -> 0)
//   i_load     : load i_load_val this edge (wins over counting)
//   i_load_val : value to load
//   o_zero     : count is zero
module dlock_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clear)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dlock_prog.sv
// dlock_prog: programmable serial code lock with failure lockout
//   i_clk        : clock, rising edge
//   i_clear      : synchronous active-high reset
//   i_d_valid    : i_d_in valid this cycle
//   i_d_in       : code bit, MSB entered first
//   i_d_abort    : discard the partial entry (beats i_d_valid)
//   i_relock     : OPEN -> LOCKED
//   i_code_we    : load i_code_in into the code register (OPEN only)
//   i_code_in    : new code
//   o_unlock     : state is OPEN
//   o_lockout    : state is LOCKOUT
//   o_fail_pulse : one cycle per failed attempt
//   o_fail_cnt   : consecutive failed attempts
// Build option: define DLOCK_AUTO_RELOCK_EN to leave OPEN automatically after UNLOCK_CYC cycles.
module dlock_prog
    import dlock_pkg::*;
#(
    parameter int                  CODE_LEN    = 6,
    parameter logic [CODE_LEN-1:0] CODE_RST    = CODE_LEN'(DEFAULT_CODE),
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 16,
    parameter int                  UNLOCK_CYC  = 64
) (
    input  logic                            i_clk,
    input  logic                            i_clear,
    input  logic                            i_d_valid,
    input  logic                            i_d_in,
    input  logic                            i_d_abort,
    input  logic                            i_relock,
    input  logic                            i_code_we,
    input  logic [CODE_LEN-1:0]             i_code_in,
    output logic                            o_unlock,
    output logic                            o_lockout,
    output logic                            o_fail_pulse,
    output logic [clog2(MAX_FAIL+1)-1:0]    o_fail_cnt
);

    localparam int BW = clog2(CODE_LEN + 1);
    localparam int FW = clog2(MAX_FAIL + 1);
    localparam int LW = clog2(LOCKOUT_CYC + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LO_LOAD   = LW'(LOCKOUT_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_LEN-1:0] r_shreg;
    logic [CODE_LEN-1:0] r_code;
    logic [BW-1:0]       r_bit_cnt;
    logic [FW-1:0]       r_fail_cnt;
    logic                w_match;
    logic                w_take;
    logic                w_lo_zero;
    logic                w_lo_load;
    logic                w_auto_relock;

    assign w_match   = (r_shreg == r_code);
    assign w_take    = i_d_valid && !i_d_abort;
    assign w_lo_load = (r_state == ST_CHECK) && (w_state_nxt == ST_LOCKOUT);

    dlock_timer #(.W(LW)) u_lockout_tmr (
        .i_clk      (i_clk),
        .i_clear    (i_clear),
        .i_load     (w_lo_load),
        .i_load_val (LO_LOAD),
        .o_zero     (w_lo_zero)
    );

`ifdef DLOCK_AUTO_RELOCK_EN
    localparam int UW = clog2(UNLOCK_CYC + 1);
    localparam logic [UW-1:0] UL_LOAD = UW'(UNLOCK_CYC - 1);
    logic w_ul_zero;
    dlock_timer #(.W(UW)) u_relock_tmr (
        .i_clk      (i_clk),
        .i_clear    (i_clear),
        .i_load     ((r_state == ST_CHECK) && w_match),
        .i_load_val (UL_LOAD),
        .o_zero     (w_ul_zero)
    );
    assign w_auto_relock = (r_state == ST_OPEN) && w_ul_zero;
`else
    logic w_unused_cfg;
    assign w_unused_cfg  = |UNLOCK_CYC;
    assign w_auto_relock = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOCKED:  w_state_nxt = (w_take && r_bit_cnt == LAST_BIT) ? ST_CHECK : ST_LOCKED;
            ST_CHECK:   w_state_nxt = w_match ? ST_OPEN : (r_fail_cnt == FAIL_LAST) ? ST_LOCKOUT : ST_LOCKED;
            ST_OPEN:    w_state_nxt = (i_relock || w_auto_relock) ? ST_LOCKED : ST_OPEN;
            ST_LOCKOUT: w_state_nxt = w_lo_zero ? ST_LOCKED : ST_LOCKOUT;
            default:    w_state_nxt = ST_LOCKED;
        endcase
    end

    // The shift register is cleared as CHECK is left, so OPEN and LOCKOUT always hold it at zero
    // and every new attempt starts from an empty register.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state    <= ST_LOCKED;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_fail_cnt <= '0;
            r_code     <= CODE_RST;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_LOCKED: begin
                    if (i_d_abort) begin
                        r_shreg   <= '0;
                        r_bit_cnt <= '0;
                    end else if (i_d_valid) begin
                        r_shreg   <= {r_shreg[CODE_LEN-2:0], i_d_in};
                        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_shreg    <= '0;
                    r_fail_cnt <= w_match ? '0 : (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 1'b1;
                end
                ST_OPEN: begin
                    if (i_code_we)
                        r_code <= i_code_in;
                end
                ST_LOCKOUT: begin
                    if (w_lo_zero)
                        r_fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_unlock     = (r_state == ST_OPEN);
    assign o_lockout    = (r_state == ST_LOCKOUT);
    assign o_fail_pulse = (r_state == ST_CHECK) && !w_match;
    assign o_fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_dlock_prog.sv
// tb_dlock_prog: scoreboard bench for dlock_prog (default parameters)
module tb_dlock_prog;

    localparam int CL = 6;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          d_valid = 1'b0;
    logic          d_in = 1'b0;
    logic          d_abort = 1'b0;
    logic          relock = 1'b0;
    logic          code_we = 1'b0;
    logic [CL-1:0] code_in = '0;
    logic          unlock;
    logic          lockout;
    logic          fail_pulse;
    logic [1:0]    fail_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int cyc;
        int fcnt;
    } exp_t;

    exp_t q[$];

    dlock_prog dut (
        .i_clk        (clk),
        .i_clear      (clear),
        .i_d_valid    (d_valid),
        .i_d_in       (d_in),
        .i_d_abort    (d_abort),
        .i_relock     (relock),
        .i_code_we    (code_we),
        .i_code_in    (code_in),
        .o_unlock     (unlock),
        .o_lockout    (lockout),
        .o_fail_pulse (fail_pulse),
        .o_fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 no result, 1 failed attempt (fcnt = count after it), 2 unlock
    task automatic send(input logic [CL-1:0] code, input int n, input int kind, input int fcnt);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            d_valid = 1'b1;
            d_in    = code[i];
            if (i == 0 && kind != 0) begin
                e.kind = kind;
                e.cyc  = (kind == 1) ? cyc + 1 : cyc + 2;
                e.fcnt = fcnt;
                q.push_back(e);
            end
        end
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    task automatic relock_t();
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        chk("relock_drops_unlock", int'(unlock), 0);
    endtask

    task automatic clear_t(input string name);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({name, "_unlock"}, int'(unlock), 0);
        chk({name, "_lockout"}, int'(lockout), 0);
        chk({name, "_fail_pulse"}, int'(fail_pulse), 0);
        chk({name, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    task automatic wait_lockout();
        int t;
        t = 0;
        while (!lockout && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("lockout_entry", int'(lockout), 1);
    endtask

    initial begin : monitor
        logic pu;
        exp_t e;
        int   k;
        pu = 1'b0;
        forever begin
            @(negedge clk);
            k  = fail_pulse ? 1 : (unlock && !pu) ? 2 : 0;
            pu = unlock;
            if (k != 0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got kind %0d want none (cyc %0d)", k, cyc);
                end else begin
                    e = q.pop_front();
                    chk("result_kind", k, e.kind);
                    chk("result_cycle", cyc, e.cyc);
                    if (k == 2) begin
                        chk("fcnt_after_unlock", int'(fail_cnt), 0);
                    end else begin
                        @(negedge clk);
                        pu = unlock;
                        chk("fail_pulse_width", int'(fail_pulse), 0);
                        chk("fcnt_after_fail", int'(fail_cnt), e.fcnt);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        int t;
        logic [CL-1:0] pat;
        pat = 6'b110100;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        chk("rst_unlock", int'(unlock), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_fail_pulse", int'(fail_pulse), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);

        // correct default code
        send(6'b110100, 6, 2, 0);
        relock_t();

        // three bad attempts, then lockout with the correct code hammered in
        send(6'b111111, 6, 1, 1);
        send(6'b111111, 6, 1, 2);
        send(6'b111111, 6, 1, 3);
        wait_lockout();
        n = 0;
        while (lockout && n < 100) begin
            d_valid = 1'b1;
            d_in    = pat[5 - (n % 6)];
            @(negedge clk);
            n++;
        end
        d_valid = 1'b0;
        chk("lockout_len", n, 16);
        chk("fcnt_after_lockout", int'(fail_cnt), 0);
        chk("no_unlock_from_lockout", int'(unlock), 0);
        send(6'b110100, 6, 2, 0);

        // reprogram in OPEN
        @(negedge clk);
        code_we = 1'b1;
        code_in = 6'b001011;
        @(negedge clk);
        code_we = 1'b0;
        relock_t();
        send(6'b110100, 6, 1, 1);
        send(6'b001011, 6, 2, 0);
        @(negedge clk);
        code_we = 1'b1;
        code_in = 6'b110100;
        relock  = 1'b1;
        @(negedge clk);
        code_we = 1'b0;
        relock  = 1'b0;
        chk("relock_with_write", int'(unlock), 0);
        @(negedge clk);
        code_we = 1'b1;
        code_in = 6'b111111;
        @(negedge clk);
        code_we = 1'b0;
        send(6'b110100, 6, 2, 0);
        relock_t();

        // abort handling
        send(6'b000110, 3, 0, 0);
        @(negedge clk);
        d_abort = 1'b1;
        @(negedge clk);
        d_abort = 1'b0;
        send(6'b110100, 6, 2, 0);
        relock_t();
        @(negedge clk);
        d_valid = 1'b1;
        d_in    = 1'b1;
        d_abort = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        d_abort = 1'b0;
        send(6'b110100, 6, 2, 0);

        // clear in OPEN after rewriting the code, mid-entry, and in LOCKOUT
        @(negedge clk);
        code_we = 1'b1;
        code_in = 6'b001011;
        @(negedge clk);
        code_we = 1'b0;
        clear_t("clr_open");
        send(6'b110100, 6, 2, 0);
        relock_t();
        send(6'b000110, 3, 0, 0);
        clear_t("clr_entry");
        send(6'b110100, 6, 2, 0);
        relock_t();
        send(6'b000000, 6, 1, 1);
        send(6'b000000, 6, 1, 2);
        send(6'b000000, 6, 1, 3);
        wait_lockout();
        clear_t("clr_lockout");
        send(6'b110100, 6, 2, 0);

`ifdef DLOCK_AUTO_RELOCK_EN
        relock_t();
        send(6'b110100, 6, 2, 0);
        t = 0;
        while (!unlock && t < 20) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (unlock && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("auto_relock_len", n, 64);
        send(6'b110100, 6, 2, 0);
        repeat (5) @(negedge clk);
        relock_t();
`endif

        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
